// File: rtl/tdc_pkg.sv
// tdc_pkg: shared sample width, window state encoding and sample type for the TDC stats path.
package tdc_pkg;
    localparam int TDC_DATA_W = 21;
    typedef enum logic [1:0] {ST_IDLE, ST_ACCUM, ST_HOLD} tdc_state_e;
    typedef logic [TDC_DATA_W-1:0] tdc_sample_t;
endpackage

// File: rtl/tdc_minmax_track.sv
// tdc_minmax_track: running per-window min/max; the *_nx outputs include the sample being accepted now.
module tdc_minmax_track
    import tdc_pkg::*;
#(
    parameter int DATA_W = TDC_DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              load_i,
    input  logic              upd_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] lo_nx_o,
    output logic [DATA_W-1:0] hi_nx_o
);
    logic [DATA_W-1:0] lo_q, hi_q;

    always_comb begin
        lo_nx_o = (load_i || data_i < lo_q) ? data_i : lo_q;
        hi_nx_o = (load_i || data_i > hi_q) ? data_i : hi_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i || clear_i) begin
            lo_q <= '0;
            hi_q <= '0;
        end else if (upd_i) begin
            lo_q <= lo_nx_o;
            hi_q <= hi_nx_o;
        end
    end
endmodule

// File: rtl/tdc_stats_accum.sv
// tdc_stats_accum: windowed mean (plus min/max when TDC_STATS_MINMAX_EN is defined) of TDC samples
// with a valid/ready result port and a saturating count of samples dropped while a result waits.
module tdc_stats_accum
    import tdc_pkg::*;
#(
    parameter int DATA_W = TDC_DATA_W,
    parameter int LOG2_N = 4,
    parameter int DROP_W = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_mean,
    output logic [DATA_W-1:0] out_min,
    output logic [DATA_W-1:0] out_max,
    output logic [DROP_W-1:0] out_drops
);
    localparam int ACC_W = DATA_W + LOG2_N;

    tdc_state_e        state_q, state_d;
    logic [ACC_W-1:0]  sum_q, sum_d, sum_nx;
    logic [LOG2_N-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] mean_q, mean_d;
    logic [DROP_W-1:0] drops_q, drops_d;
    logic              hold, hs, accept, last;

    always_comb begin
        hold    = state_q == ST_HOLD;
        hs      = hold && out_ready;
        accept  = !clear && in_valid && (!hold || out_ready);
        last    = accept && state_q == ST_ACCUM && cnt_q == '1;
        sum_nx  = sum_q + ACC_W'(in_data);
        state_d = clear ? ST_IDLE : last ? ST_HOLD : (hold && !out_ready) ? ST_HOLD :
                  accept ? ST_ACCUM : hold ? ST_IDLE : state_q;
        sum_d   = (clear || last) ? '0 : accept ? sum_nx : sum_q;
        cnt_d   = clear ? '0 : accept ? cnt_q + 1'b1 : cnt_q;
        mean_d  = clear ? '0 : last ? DATA_W'(sum_nx >> LOG2_N) : mean_q;
        drops_d = (clear || hs) ? '0 : (hold && in_valid && drops_q != '1) ? drops_q + 1'b1 : drops_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            sum_q   <= '0;
            cnt_q   <= '0;
            mean_q  <= '0;
            drops_q <= '0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            mean_q  <= mean_d;
            drops_q <= drops_d;
        end
    end

    assign out_valid = state_q == ST_HOLD;
    assign out_mean  = mean_q;
    assign out_drops = drops_q;

`ifdef TDC_STATS_MINMAX_EN
    logic [DATA_W-1:0] lo_nx, hi_nx, min_q, max_q;

    tdc_minmax_track #(.DATA_W(DATA_W)) u_track (
        .clk_i   (CLK),
        .rst_i   (RST),
        .clear_i (clear),
        .load_i  (accept && state_q != ST_ACCUM),
        .upd_i   (accept),
        .data_i  (in_data),
        .lo_nx_o (lo_nx),
        .hi_nx_o (hi_nx)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST || clear) begin
            min_q <= '0;
            max_q <= '0;
        end else if (last) begin
            min_q <= lo_nx;
            max_q <= hi_nx;
        end
    end

    assign out_min = min_q;
    assign out_max = max_q;
`else
    assign out_min = '0;
    assign out_max = '0;
`endif
endmodule

// File: tb/tb_tdc_stats_accum.sv
// tb_tdc_stats_accum: directed checks of mean, min/max, drops, handshake, clear and async reset.
module tb_tdc_stats_accum;
    import tdc_pkg::*;

`ifdef TDC_STATS_MINMAX_EN
    localparam bit MM = 1'b1;
`else
    localparam bit MM = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    tdc_sample_t in_data = '0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    tdc_sample_t out_mean, out_min, out_max;
    logic [7:0]  out_drops;
    int          checks = 0;
    int          failures = 0;

    tdc_stats_accum dut (
        .CLK       (CLK),
        .RST       (RST),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mean  (out_mean),
        .out_min   (out_min),
        .out_max   (out_max),
        .out_drops (out_drops)
    );

    always #5 CLK = ~CLK;

    function automatic tdc_sample_t mm(input tdc_sample_t v);
        return MM ? v : '0;
    endfunction

    task automatic step(input logic v, input tdc_sample_t d);
        in_valid = v;
        in_data  = d;
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_n(input int n, input tdc_sample_t base, input tdc_sample_t inc);
        for (int i = 0; i < n; i++) step(1'b1, tdc_sample_t'(base + i * inc));
    endtask

    task automatic test_reset;
        #12;
        checks++;
        if ({out_valid, out_mean, out_min, out_max, out_drops} !== '0) begin
            failures++;
            $display("FAIL reset: got v=%0b mean=%0d min=%0d max=%0d drops=%0d want all 0",
                     out_valid, out_mean, out_min, out_max, out_drops);
        end
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_constant;
        out_ready = 1'b1;
        send_n(15, 100, 0);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL const_early: got valid=%0b want 0", out_valid);
        end
        step(1'b1, 100);
        checks++;
        if ({out_valid, out_mean, out_min, out_max} !== {1'b1, 21'd100, mm(100), mm(100)}) begin
            failures++;
            $display("FAIL const_result: got v=%0b mean=%0d min=%0d max=%0d want 1/100/%0d/%0d",
                     out_valid, out_mean, out_min, out_max, mm(100), mm(100));
        end
        step(1'b0, 0);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL const_handshake: got valid=%0b want 0", out_valid);
        end
    endtask

    task automatic test_ramp;
        send_n(16, 0, 1);
        checks++;
        if ({out_valid, out_mean, out_min, out_max} !== {1'b1, 21'd7, mm(0), mm(15)}) begin
            failures++;
            $display("FAIL ramp: got v=%0b mean=%0d min=%0d max=%0d want 1/7/%0d/%0d",
                     out_valid, out_mean, out_min, out_max, mm(0), mm(15));
        end
        step(1'b0, 0);
    endtask

    task automatic test_extremes;
        send_n(16, 2097151, 0);
        checks++;
        if ({out_valid, out_mean, out_min, out_max} !== {1'b1, 21'd2097151, mm(2097151), mm(2097151)}) begin
            failures++;
            $display("FAIL full_scale: got v=%0b mean=%0d min=%0d max=%0d want 1/2097151",
                     out_valid, out_mean, out_min, out_max);
        end
        step(1'b0, 0);
        send_n(16, 0, 0);
        checks++;
        if ({out_valid, out_mean, out_min, out_max} !== {1'b1, 21'd0, 21'd0, 21'd0}) begin
            failures++;
            $display("FAIL zeros: got v=%0b mean=%0d min=%0d max=%0d want 1/0/0/0",
                     out_valid, out_mean, out_min, out_max);
        end
        step(1'b0, 0);
    endtask

    task automatic test_drops;
        out_ready = 1'b0;
        send_n(16, 40, 0);
        send_n(5, 77, 1);
        checks++;
        if ({out_valid, out_mean, out_drops} !== {1'b1, 21'd40, 8'd5}) begin
            failures++;
            $display("FAIL drops: got v=%0b mean=%0d drops=%0d want 1/40/5",
                     out_valid, out_mean, out_drops);
        end
        out_ready = 1'b1;
        step(1'b1, 7);
        checks++;
        if ({out_valid, out_drops} !== {1'b0, 8'd0}) begin
            failures++;
            $display("FAIL drops_hs: got v=%0b drops=%0d want 0/0", out_valid, out_drops);
        end
        send_n(14, 7, 0);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL hs_cnt_early: got valid=%0b want 0 after 15 samples", out_valid);
        end
        step(1'b1, 7);
        checks++;
        if ({out_valid, out_mean, out_min, out_max} !== {1'b1, 21'd7, mm(7), mm(7)}) begin
            failures++;
            $display("FAIL hs_cnt_result: got v=%0b mean=%0d min=%0d max=%0d want 1/7",
                     out_valid, out_mean, out_min, out_max);
        end
        step(1'b0, 0);
    endtask

    task automatic test_saturate;
        out_ready = 1'b0;
        send_n(16, 1, 0);
        send_n(260, 5, 0);
        checks++;
        if ({out_valid, out_mean, out_drops} !== {1'b1, 21'd1, 8'd255}) begin
            failures++;
            $display("FAIL drops_sat: got v=%0b mean=%0d drops=%0d want 1/1/255",
                     out_valid, out_mean, out_drops);
        end
        out_ready = 1'b1;
        step(1'b0, 0);
    endtask

    task automatic test_clear;
        send_n(7, 999, 0);
        clear = 1'b1;
        step(1'b1, 999);
        clear = 1'b0;
        checks++;
        if ({out_valid, out_mean} !== {1'b0, 21'd0}) begin
            failures++;
            $display("FAIL clear: got v=%0b mean=%0d want 0/0", out_valid, out_mean);
        end
        send_n(15, 50, 0);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL clear_early: got valid=%0b want 0", out_valid);
        end
        step(1'b1, 50);
        checks++;
        if ({out_valid, out_mean, out_min, out_max} !== {1'b1, 21'd50, mm(50), mm(50)}) begin
            failures++;
            $display("FAIL clear_result: got v=%0b mean=%0d min=%0d max=%0d want 1/50",
                     out_valid, out_mean, out_min, out_max);
        end
        step(1'b0, 0);
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 32; i++) begin
            step(1'b1, (i < 16) ? 21'd20 : 21'd30 + 21'(i[0]));
            if (i == 15 || i == 31) begin
                checks++;
                if ({out_valid, out_mean} !== {1'b1, (i == 15) ? 21'd20 : 21'd30}) begin
                    failures++;
                    $display("FAIL b2b_%0d: got v=%0b mean=%0d want 1/%0d",
                             i, out_valid, out_mean, (i == 15) ? 20 : 30);
                end
            end else if (i == 16) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b_gap: got valid=%0b want 0", out_valid);
                end
            end
        end
        step(1'b0, 0);
    endtask

    task automatic test_async_reset;
        out_ready = 1'b0;
        send_n(16, 9, 0);
        step(1'b1, 9);
        #2;
        RST = 1'b1;
        #1;
        checks++;
        if ({out_valid, out_mean, out_min, out_max, out_drops} !== '0) begin
            failures++;
            $display("FAIL async_rst: got v=%0b mean=%0d min=%0d max=%0d drops=%0d want all 0",
                     out_valid, out_mean, out_min, out_max, out_drops);
        end
        RST = 1'b0;
        out_ready = 1'b1;
        @(posedge CLK);
        #1;
        send_n(16, 3, 0);
        checks++;
        if ({out_valid, out_mean, out_min, out_max} !== {1'b1, 21'd3, mm(3), mm(3)}) begin
            failures++;
            $display("FAIL post_rst: got v=%0b mean=%0d min=%0d max=%0d want 1/3",
                     out_valid, out_mean, out_min, out_max);
        end
    endtask

    initial begin
        test_reset;
        test_constant;
        test_ramp;
        test_extremes;
        test_drops;
        test_saturate;
        test_clear;
        test_back_to_back;
        test_async_reset;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
